mem_access_unit: RTL

Memory stage of the 5-stage MIPS pipeline: consumes the EX/MEM register outputs, performs load/store through a request/acknowledge data-memory port, and registers the results into the MEM/WB boundary. Stalls the upstream pipeline while an access is outstanding. Turns the single-cycle memory assumption into a variable-latency access.

---
 rtl/mips_pkg.sv | 16 +
 rtl/mem_wb_reg.sv | 39 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: M-field bit positions, FSM states, width defaults.
package mips_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;

    // Bit positions inside the 2-bit M control field
    localparam int unsigned M_READ  = 1;
    localparam int unsigned M_WRITE = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mau_state_e;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: full load of a retiring instruction, or a bubble that only clears RegWrite.
module mem_wb_reg
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              bubble,
    input  logic              wb_in,
    input  logic [DATA_W-1:0] read_data_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [REG_W-1:0]  write_register_in,
    output logic              wb_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [REG_W-1:0]  write_register_out
);

    // Load wins over bubble; a bubble leaves the data fields untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_out             <= 1'b0;
            read_data_out      <= '0;
            alu_out            <= '0;
            write_register_out <= '0;
        end else if (load) begin
            wb_out             <= wb_in;
            read_data_out      <= read_data_in;
            alu_out            <= alu_in;
            write_register_out <= write_register_in;
        end else if (bubble) begin
            wb_out             <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS memory stage: variable-latency load/store over a req/ack port, stalling upstream while busy.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WB_in,
    input  logic [1:0]        M_in,
    input  logic [DATA_W-1:0] ALUresult_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [REG_W-1:0]  write_register_in,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_error,
    output logic              WB_out,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] ALUresult_out,
    output logic [REG_W-1:0]  write_register_out
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    mau_state_e        state;
    mau_state_e        next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              access;
    logic              timeout_hit;
    logic              done;
    logic              issue;
    logic              wb_load;
    logic              wb_bubble;
    logic [DATA_W-1:0] wb_rdata;

    assign access      = M_in[M_READ] | M_in[M_WRITE];
    // Timeout fires on the TIMEOUT-th WAIT cycle without an ack
    assign timeout_hit = (state == ST_WAIT) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign done        = (state == ST_WAIT) && (mem_ack || timeout_hit);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (access) next_state = ST_WAIT;
            ST_WAIT: if (done)   next_state = ST_IDLE;
            default:             next_state = ST_IDLE;
        endcase
    end

    // Stall, request issue and MEM/WB load/bubble decode
    always_comb begin
        stall     = 1'b0;
        issue     = 1'b0;
        wb_load   = 1'b0;
        wb_bubble = 1'b0;
        wb_rdata  = '0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    stall     = 1'b1;
                    issue     = 1'b1;
                    wb_bubble = 1'b1;
                end else begin
                    wb_load   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (done) begin
                    wb_load = 1'b1;
                    // mem_we low means the access was a read; a timeout leaves ack low so data is 0
                    if (mem_ack && !mem_we) wb_rdata = mem_rdata;
                end else begin
                    stall     = 1'b1;
                    wb_bubble = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request flops: captured on issue, held through WAIT, request dropped on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= M_in[M_WRITE] & ~M_in[M_READ];
            mem_addr  <= ALUresult_in;
            mem_wdata <= write_data_in;
        end else if (done) begin
            mem_req   <= 1'b0;
        end
    end

    // Wait counter: counts un-acked WAIT cycles, saturating, cleared outside an active wait
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT && !done) begin
            if (wait_cnt != CNT_W'(TIMEOUT)) wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_error <= 1'b0;
        end else if (timeout_hit) begin
            mem_error <= 1'b1;
        end
    end

    mem_wb_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W)
    ) u_mem_wb_reg (
        .clk                (clk),
        .rst                (rst),
        .load               (wb_load),
        .bubble             (wb_bubble),
        .wb_in              (WB_in),
        .read_data_in       (wb_rdata),
        .alu_in             (ALUresult_in),
        .write_register_in  (write_register_in),
        .wb_out             (WB_out),
        .read_data_out      (read_data_out),
        .alu_out            (ALUresult_out),
        .write_register_out (write_register_out)
    );

endmodule
